// File: rtl/dmem_access_unit.sv
// ============================================================================
// dmem_access_unit
// ----------------------------------------------------------------------------
// Load/store unit between the execute stage and the dmem port of the 2R1W RAM.
// Takes one byte/half/word/dword request per handshake. Drives an 8-byte-aligned
// RAM address, a bit-granular write mask and lane-shifted write data. Returns
// load data extracted from the RAM word and sign- or zero-extended.
//
// Optional feature macro: DMEM_SPLIT_EN
//   defined   : an access crossing an 8-byte boundary runs as two RAM beats.
//   undefined : the second beat is not built, and a crossing access returns
//               resp_err=1 without touching the RAM.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   req_valid/ready   request handshake (ready only while idle)
//   req_addr          byte address
//   req_wen           1=store, 0=load
//   req_size          0=B 1=H 2=W 3=D
//   req_unsigned      loads zero-extend when 1
//   req_wdata         right-justified store data
//   resp_valid/ready  response handshake
//   resp_rdata        extended load data (0 for stores and errors)
//   resp_err          out-of-window, or crossing access without split support
//   dmem_en/addr/wen  RAM strobe, aligned address, write enable
//   dmem_wdata/wmask  lane-aligned write data, 8 mask bits per enabled byte
//   dmem_rdata        combinational RAM read data for dmem_addr
// ============================================================================
module dmem_access_unit #(
    parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
    parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0800_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        dmem_en,
    output logic [63:0] dmem_addr,
    output logic        dmem_wen,
    output logic [63:0] dmem_wdata,
    output logic [63:0] dmem_wmask,
    input  logic [63:0] dmem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT0 = 2'd1;
    localparam logic [1:0] ST_BEAT1 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Bit mask for the byte lanes touched in one beat. The access occupies
    // lanes off..off+n-1 of a 16-lane window; 'upper' picks the second beat.
    function automatic logic [63:0] lane_mask(input logic [2:0] off,
                                              input logic [1:0] size,
                                              input logic       upper);
        logic [7:0]  n_mask;
        logic [15:0] lanes;
        logic [7:0]  sel;
        case (size)
            2'd0:    n_mask = 8'h01;
            2'd1:    n_mask = 8'h03;
            2'd2:    n_mask = 8'h0F;
            default: n_mask = 8'hFF;
        endcase
        lanes = {8'h00, n_mask} << off;
        sel   = upper ? lanes[15:8] : lanes[7:0];
        for (int i = 0; i < 8; i++) begin
            lane_mask[8*i +: 8] = {8{sel[i]}};
        end
    endfunction

    // Realign {hi,lo} so the addressed byte sits at bit 0, then extend to 64 bits.
    // A zero offset would make the hi shift 64, so that case is forced to 0.
    function automatic logic [63:0] extend_load(input logic [63:0] lo,
                                                input logic [63:0] hi,
                                                input logic [2:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [6:0]  sh;
        logic [63:0] raw;
        sh  = {1'b0, off, 3'b000};
        raw = (lo >> sh) | ((sh == 7'd0) ? 64'h0 : (hi << (7'd64 - sh)));
        case (size)
            2'd0:    extend_load = uns ? {56'h0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    extend_load = uns ? {48'h0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    extend_load = uns ? {32'h0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            default: extend_load = raw;
        endcase
    endfunction

    logic [1:0]  state_q, state_d;
    logic [2:0]  off_q, off_d;
    logic [1:0]  size_q, size_d;
    logic        wen_q, wen_d;
    logic        uns_q, uns_d;
`ifdef DMEM_SPLIT_EN
    logic        cross_q, cross_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] lo_q, lo_d;
`endif
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        dmem_en_q, dmem_en_d;
    logic [63:0] dmem_addr_q, dmem_addr_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic [63:0] dmem_wdata_q, dmem_wdata_d;
    logic [63:0] dmem_wmask_q, dmem_wmask_d;

    logic [3:0]  nbytes_s;
    logic [3:0]  end_off_s;
    logic        cross_s;
    logic [64:0] end_addr_s;
    logic [64:0] limit_s;
    logic        req_err_s;

    // Decode the incoming request: size in bytes, boundary crossing, window check.
    always_comb begin
        nbytes_s   = 4'd1 << req_size;
        end_off_s  = {1'b0, req_addr[2:0]} + nbytes_s;
        cross_s    = (end_off_s > 4'd8);
        // 65-bit sums so an address near 2^64 cannot wrap back into the window.
        end_addr_s = {1'b0, req_addr} + {61'd0, nbytes_s};
        limit_s    = {1'b0, MEM_BASE} + {1'b0, MEM_SIZE};
`ifdef DMEM_SPLIT_EN
        req_err_s  = (req_addr < MEM_BASE) || (end_addr_s > limit_s);
`else
        req_err_s  = (req_addr < MEM_BASE) || (end_addr_s > limit_s) || cross_s;
`endif
    end

    // Next-state and next-output logic; every output is registered from here.
    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        size_d       = size_q;
        wen_d        = wen_q;
        uns_d        = uns_q;
`ifdef DMEM_SPLIT_EN
        cross_d      = cross_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
`endif
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        // RAM port idles at zero unless the next state is a beat.
        dmem_en_d    = 1'b0;
        dmem_addr_d  = 64'h0;
        dmem_wen_d   = 1'b0;
        dmem_wdata_d = 64'h0;
        dmem_wmask_d = 64'h0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    off_d       = req_addr[2:0];
                    size_d      = req_size;
                    wen_d       = req_wen;
                    uns_d       = req_unsigned;
`ifdef DMEM_SPLIT_EN
                    cross_d     = cross_s;
                    wdata_d     = req_wdata;
`endif
                    req_ready_d = 1'b0;
                    if (req_err_s) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 64'h0;
                    end else begin
                        state_d      = ST_BEAT0;
                        dmem_en_d    = 1'b1;
                        dmem_addr_d  = {req_addr[63:3], 3'b000};
                        dmem_wen_d   = req_wen;
                        dmem_wdata_d = req_wdata << {req_addr[2:0], 3'b000};
                        dmem_wmask_d = lane_mask(req_addr[2:0], req_size, 1'b0);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEAT0: begin
`ifdef DMEM_SPLIT_EN
                if (cross_q) begin
                    state_d      = ST_BEAT1;
                    lo_d         = dmem_rdata;
                    dmem_en_d    = 1'b1;
                    dmem_addr_d  = dmem_addr_q + 64'd8;
                    dmem_wen_d   = wen_q;
                    // Bytes that spilled past lane 7 land at the bottom of the next word.
                    dmem_wdata_d = wdata_q >> (7'd64 - {1'b0, off_q, 3'b000});
                    dmem_wmask_d = lane_mask(off_q, size_q, 1'b1);
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = wen_q ? 64'h0 : extend_load(dmem_rdata, 64'h0, off_q, size_q, uns_q);
                end
`else
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = wen_q ? 64'h0 : extend_load(dmem_rdata, 64'h0, off_q, size_q, uns_q);
`endif
            end
`ifdef DMEM_SPLIT_EN
            ST_BEAT1: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = wen_q ? 64'h0 : extend_load(lo_q, dmem_rdata, off_q, size_q, uns_q);
            end
`endif
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 64'h0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                // Unreachable encodings fall back to a clean idle.
                state_d      = ST_IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 64'h0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            off_q        <= 3'd0;
            size_q       <= 2'd0;
            wen_q        <= 1'b0;
            uns_q        <= 1'b0;
`ifdef DMEM_SPLIT_EN
            cross_q      <= 1'b0;
            wdata_q      <= 64'h0;
            lo_q         <= 64'h0;
`endif
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 64'h0;
            dmem_en_q    <= 1'b0;
            dmem_addr_q  <= 64'h0;
            dmem_wen_q   <= 1'b0;
            dmem_wdata_q <= 64'h0;
            dmem_wmask_q <= 64'h0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            size_q       <= size_d;
            wen_q        <= wen_d;
            uns_q        <= uns_d;
`ifdef DMEM_SPLIT_EN
            cross_q      <= cross_d;
            wdata_q      <= wdata_d;
            lo_q         <= lo_d;
`endif
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            dmem_en_q    <= dmem_en_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_wdata_q <= dmem_wdata_d;
            dmem_wmask_q <= dmem_wmask_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign dmem_en    = dmem_en_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_wdata = dmem_wdata_q;
    assign dmem_wmask = dmem_wmask_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ============================================================================
// tb_dmem_access_unit
// Directed and randomized requests against dmem_access_unit. A small RAM
// (64 words, aliased on address bits [8:3]) sits on the dmem port. A byte-level
// reference memory, also aliased modulo 512 bytes, predicts load data, beat
// addresses, masks, write data, latency and errors.
// ============================================================================
module tb_dmem_access_unit;

    localparam logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MEM_SIZE = 64'h0000_0000_0800_0000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        dmem_en;
    logic [63:0] dmem_addr;
    logic        dmem_wen;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_wmask;
    logic [63:0] dmem_rdata;

    dmem_access_unit #(.MEM_BASE(MEM_BASE), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .dmem_en(dmem_en), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM harness: combinational read, masked write at the edge ending a beat.
    logic [63:0] ram [0:63];
    logic        ram_clear;
    logic [5:0]  ram_idx;
    assign ram_idx    = dmem_addr[8:3];
    assign dmem_rdata = ram[ram_idx];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 64; i++) ram[i] <= 64'h0;
        end else if (dmem_en && dmem_wen) begin
            ram[ram_idx] <= (ram[ram_idx] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
        end
    end

    // Reference byte memory.
    logic [7:0] mm [0:511];

    int n_cmp;
    int n_bad;

    logic [63:0] last_rd, last_b0a, last_b0m, last_b0d, last_b1a, last_b1m, last_b1d;
    logic        last_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"},  64'(req_ready),  64'd1);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_err"},   64'(resp_err),   64'd0);
        check({tag, "_resp_rdata"}, resp_rdata,      64'd0);
        check({tag, "_dmem_en"},    64'(dmem_en),    64'd0);
        check({tag, "_dmem_addr"},  dmem_addr,       64'd0);
        check({tag, "_dmem_wen"},   64'(dmem_wen),   64'd0);
        check({tag, "_dmem_wdata"}, dmem_wdata,      64'd0);
        check({tag, "_dmem_wmask"}, dmem_wmask,      64'd0);
    endtask

    // One full transaction, entered and left at posedge+1 with the unit idle.
    task automatic do_req(input logic [63:0] a, input logic w, input logic [1:0] sz,
                          input logic u, input logic [63:0] wd, input int hold);
        int          n, off, exp_beats, lat, nb;
        logic        exp_err;
        logic [64:0] end65;
        logic [63:0] exp_rd, b0m, b1m, b0d, b1d, v;
        logic [63:0] ba [2];
        logic [63:0] bm [2];
        logic [63:0] bd [2];
        logic        bw [2];
        n     = 1 << sz;
        off   = int'(a[2:0]);
        end65 = {1'b0, a} + 65'(n);
        exp_err   = (a < MEM_BASE) || (end65 > ({1'b0, MEM_BASE} + {1'b0, MEM_SIZE}));
        exp_beats = (off + n > 8) ? 2 : 1;
`ifndef DMEM_SPLIT_EN
        if (off + n > 8) exp_err = 1'b1;
`endif
        if (exp_err) exp_beats = 0;
        b0m = 64'h0;
        b1m = 64'h0;
        for (int i = 0; i < n; i++) begin
            if (off + i < 8) b0m[8*(off+i) +: 8] = 8'hFF;
            else             b1m[8*(off+i-8) +: 8] = 8'hFF;
        end
        b0d = wd << (8 * off);
        b1d = (off == 0) ? 64'h0 : (wd >> (8 * (8 - off)));
        v = 64'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[(int'(a[8:0]) + i) % 512];
        if (!u && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
        exp_rd = (exp_err || w) ? 64'h0 : v;

        last_b0a = 64'h0; last_b0m = 64'h0; last_b0d = 64'h0;
        last_b1a = 64'h0; last_b1m = 64'h0; last_b1d = 64'h0;
        check("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_addr = a; req_wen = w; req_size = sz;
        req_unsigned = u; req_wdata = wd;
        @(posedge clk); #1;
        // Scramble inputs so anything not latched at the handshake shows up.
        req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
        req_wen = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        lat = 1;
        nb  = 0;
        while (!resp_valid && lat < 8) begin
            check("req_ready_busy", 64'(req_ready), 64'd0);
            if (dmem_en) begin
                if (nb < 2) begin
                    ba[nb] = dmem_addr; bm[nb] = dmem_wmask; bd[nb] = dmem_wdata; bw[nb] = dmem_wen;
                end
                nb++;
            end
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(exp_beats + 1));
        check("beats", 64'(nb), 64'(exp_beats));
        check("resp_err", 64'(resp_err), 64'(exp_err));
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_dmem_idle", 64'(dmem_en), 64'd0);
        check("resp_req_ready", 64'(req_ready), 64'd0);
        if (nb >= 1 && exp_beats >= 1) begin
            last_b0a = ba[0]; last_b0m = bm[0]; last_b0d = bd[0];
            check("b0_addr", ba[0], {a[63:3], 3'b000});
            check("b0_wen", 64'(bw[0]), 64'(w));
            if (w) begin
                check("b0_mask", bm[0], b0m);
                check("b0_data", bd[0], b0d);
            end
        end
        if (nb >= 2 && exp_beats == 2) begin
            last_b1a = ba[1]; last_b1m = bm[1]; last_b1d = bd[1];
            check("b1_addr", ba[1], {a[63:3], 3'b000} + 64'd8);
            check("b1_wen", 64'(bw[1]), 64'(w));
            if (w) begin
                check("b1_mask", bm[1], b1m);
                check("b1_data", bd[1], b1d);
            end
        end
        last_rd  = resp_rdata;
        last_err = resp_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(resp_valid), 64'd1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_err", 64'(resp_err), 64'(exp_err));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("post_resp_valid", 64'(resp_valid), 64'd0);
        check("post_req_ready", 64'(req_ready), 64'd1);
        if (w && !exp_err) begin
            for (int i = 0; i < n; i++) mm[(int'(a[8:0]) + i) % 512] = wd[8*i +: 8];
        end
    endtask

    initial begin
        logic [63:0] a, wd;
        logic [1:0]  sz;
        logic        w, u;
        int          off, n, pick;
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; ram_clear = 1'b1; resp_ready = 1'b0;
        req_valid = 1'b0; req_addr = 64'h0; req_wen = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 64'h0;
        for (int i = 0; i < 512; i++) mm[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1; ram_clear = 1'b0;
        @(posedge clk); #1;

        // Aligned dword store then load.
        do_req(64'h8000_0010, 1'b1, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 0);
        do_req(64'h8000_0010, 1'b0, 2'd3, 1'b0, 64'h0, 0);
        check("t1_ld", last_rd, 64'h1122_3344_5566_7788);

        // Byte 0x85 at offset 3, signed and unsigned loads.
        do_req(64'h8000_0013, 1'b1, 2'd0, 1'b0, 64'hDEAD_BEEF_0000_0085, 1);
        do_req(64'h8000_0013, 1'b0, 2'd0, 1'b0, 64'h0, 0);
        check("t2_lb_addr", last_b0a, 64'h8000_0010);
        check("t2_lb_signed", last_rd, 64'hFFFF_FFFF_FFFF_FF85);
        do_req(64'h8000_0013, 1'b0, 2'd0, 1'b1, 64'h0, 0);
        check("t2_lb_unsigned", last_rd, 64'h0000_0000_0000_0085);

        // Halfword store into the top two lanes.
        do_req(64'h8000_0006, 1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF, 0);
        check("t3_mask", last_b0m, 64'hFFFF_0000_0000_0000);
        check("t3_data", last_b0d, 64'hBEEF_0000_0000_0000);

        // Word store straddling the 8-byte boundary.
        do_req(64'h8000_0006, 1'b1, 2'd2, 1'b0, 64'h0000_0000_A1B2_C3D4, 0);
`ifdef DMEM_SPLIT_EN
        check("t4_b0_addr", last_b0a, 64'h8000_0000);
        check("t4_b0_mask", last_b0m, 64'hFFFF_0000_0000_0000);
        check("t4_b0_data", last_b0d, 64'hC3D4_0000_0000_0000);
        check("t4_b1_addr", last_b1a, 64'h8000_0008);
        check("t4_b1_mask", last_b1m, 64'h0000_0000_0000_FFFF);
        check("t4_b1_data", last_b1d, 64'h0000_0000_0000_A1B2);
        do_req(64'h8000_0006, 1'b0, 2'd2, 1'b0, 64'h0, 0);
        check("t4_readback", last_rd, 64'hFFFF_FFFF_A1B2_C3D4);
`else
        check("t4_err", 64'(last_err), 64'd1);
        do_req(64'h8000_0000, 1'b0, 2'd3, 1'b0, 64'h0, 0);
        check("t4_ram_unchanged", last_rd, 64'hBEEF_0000_0000_0000);
`endif

        // Window edges.
        do_req(64'h7FFF_FFF8, 1'b0, 2'd3, 1'b0, 64'h0, 0);
        check("t5_below_base", 64'(last_err), 64'd1);
        do_req(64'h87FF_FFFC, 1'b0, 2'd2, 1'b0, 64'h0, 0);
        check("t5_last_word", 64'(last_err), 64'd0);
        do_req(64'h87FF_FFFD, 1'b0, 2'd2, 1'b0, 64'h0, 0);
        check("t5_past_end", 64'(last_err), 64'd1);
        do_req(64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 2'd3, 1'b0, 64'h0, 0);
        check("t5_wrap", 64'(last_err), 64'd1);

        // Consumer stalls for five cycles.
        do_req(64'h8000_0010, 1'b0, 2'd3, 1'b0, 64'h0, 5);

        // Reset landing on the edge that closes beat 0 of a store.
`ifdef DMEM_SPLIT_EN
        a = 64'h8000_0006; sz = 2'd2;
`else
        a = 64'h8000_0028; sz = 2'd3;
`endif
        wd = 64'h0102_0304_5566_7788;
        req_valid = 1'b1; req_addr = a; req_wen = 1'b1; req_size = sz;
        req_unsigned = 1'b0; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_beat0_en", 64'(dmem_en), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        off = int'(a[2:0]);
        n   = 1 << sz;
        for (int i = 0; i < n; i++) begin
            if (off + i < 8) mm[(int'(a[8:0]) + i) % 512] = wd[8*i +: 8];
        end
        do_req({a[63:3], 3'b000}, 1'b0, 2'd3, 1'b0, 64'h0, 0);
        do_req({a[63:3], 3'b000} + 64'd8, 1'b0, 2'd3, 1'b0, 64'h0, 0);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            sz   = 2'($urandom_range(0, 3));
            w    = 1'($urandom_range(0, 1));
            u    = 1'($urandom_range(0, 1));
            wd   = {$urandom, $urandom};
            pick = $urandom_range(0, 19);
            if (pick == 0)      a = 64'h7FFF_FFF8 + 64'($urandom_range(0, 7));
            else if (pick == 1) a = 64'h87FF_FFF8 + 64'($urandom_range(0, 7));
            else if (pick == 2) a = {$urandom, $urandom};
            else                a = MEM_BASE + 64'($urandom_range(0, 511));
            do_req(a, w, sz, u, wd, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
